// File: rtl/uart_reg_rx.sv
// Oversampling serial register-write receiver: frames start/payload/[parity]/stop
// and turns each good frame into a bank-select update or a banked register write.
module uart_reg_rx #(
  parameter int OVERSAMPLE = 5,
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 4,
  parameter int BANK_W     = 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BANK_W+ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [BANK_W-1:0]        bank_sel,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overrun
);
  localparam int N  = DATA_W + ADDR_W + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(N + 1);

  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic          rx_s1, rx_s2, rx_s3;
  logic [2:0]    state;
  logic [TW-1:0] tick;
  logic [BW-1:0] bitcnt;
  logic [N-1:0]  shreg;
  logic          perr;

  logic fall, sample_end, stop_done, frame_ok, flag, load_ok;

  assign fall       = rx_s3 & ~rx_s2;
  assign sample_end = (tick == TICK_END);
  assign stop_done  = (state == STOP) && sample_end;
  assign frame_ok   = stop_done & rx_s2 & ~perr;
  assign flag       = shreg[N-1];
  assign load_ok    = frame_ok & ~flag & (~out_valid | out_ready);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      state      <= IDLE;
      tick       <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      bank_sel   <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_s3      <= rx_s2;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;

      case (state)
        IDLE: begin
          tick   <= '0;
          bitcnt <= '0;
          perr   <= 1'b0;
          if (fall) state <= START;
        end
        START: begin
          // A start bit that is high again by mid-bit was only a glitch.
          if (tick == TICK_MID) begin
            tick  <= '0;
            state <= rx_s2 ? IDLE : DATA;
          end else tick <= tick + 1'b1;
        end
        DATA: begin
          if (sample_end) begin
            tick   <= '0;
            shreg  <= {rx_s2, shreg[N-1:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else tick <= tick + 1'b1;
        end
        PARITY: begin
          if (sample_end) begin
            tick  <= '0;
            perr  <= ((^shreg) ^ rx_s2) != 1'(PARITY_ODD);
            state <= STOP;
          end else tick <= tick + 1'b1;
        end
        STOP: begin
          // Back to IDLE at mid-stop so the next start edge is not missed.
          if (sample_end) begin
            tick  <= '0;
            state <= IDLE;
          end else tick <= tick + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (stop_done && !rx_s2) frame_err <= 1'b1;
      if (stop_done && rx_s2 && perr) parity_err <= 1'b1;
      if (frame_ok && flag) bank_sel <= shreg[BANK_W-1:0];

      if (frame_ok && !flag && out_valid && !out_ready) overrun <= 1'b1;

      if (load_ok) begin
        out_valid <= 1'b1;
        out_addr  <= {bank_sel, shreg[DATA_W+ADDR_W-1:DATA_W]};
        out_data  <= shreg[DATA_W-1:0];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_reg_rx.sv
// Directed bench for uart_reg_rx: default instance plus an even-parity instance.
module tb_uart_reg_rx;
  localparam int OS = 5;

  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_p = 1'b1, out_ready = 1'b1;

  logic       out_valid, busy, frame_err, parity_err, overrun;
  logic [4:0] out_addr;
  logic [3:0] out_data;
  logic [1:0] bank_sel;

  logic       out_valid_p, busy_p, frame_err_p, parity_err_p, overrun_p;
  logic [4:0] out_addr_p;
  logic [3:0] out_data_p;
  logic [1:0] bank_sel_p;

  uart_reg_rx u_dut (
    .clk(clk), .rst(rst), .rx(rx), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .bank_sel(bank_sel), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  uart_reg_rx #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .rx(rx_p), .out_valid(out_valid_p), .out_ready(1'b1),
    .out_addr(out_addr_p), .out_data(out_data_p), .bank_sel(bank_sel_p), .busy(busy_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p)
  );

  always #5 clk = ~clk;

  int vld_cyc = 0, hs_cnt = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  int hs_p = 0, pe_p = 0, fe_p = 0;
  logic [4:0] hs_addr = '0, hs_addr_p = '0;
  logic [3:0] hs_data = '0, hs_data_p = '0;

  // Event monitors on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) vld_cyc++;
      if (out_valid && out_ready) begin hs_cnt++; hs_addr = out_addr; hs_data = out_data; end
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overrun) ov_cnt++;
      if (out_valid_p) begin hs_p++; hs_addr_p = out_addr_p; hs_data_p = out_data_p; end
      if (parity_err_p) pe_p++;
      if (frame_err_p) fe_p++;
    end
  end

  int tests = 0, failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drive(input bit par, input logic b);
    if (par) rx_p = b; else rx = b;
    tick(OS);
  endtask

  task automatic send(input logic [7:0] p, input logic stopb, input bit par, input logic pb);
    drive(par, 1'b0);
    for (int i = 0; i < 8; i++) drive(par, p[i]);
    if (par) drive(par, pb);
    drive(par, stopb);
    if (par) rx_p = 1'b1; else rx = 1'b1;
    tick(2 * OS);
  endtask

  initial begin
    tick(3);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_addr", 32'(out_addr), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_bank", 32'(bank_sel), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick(5);

    // Plain write, consumer ready.
    send(8'h3A, 1'b1, 1'b0, 1'b0);
    check("w1_vld_cycles", 32'(vld_cyc), 1);
    check("w1_hs", 32'(hs_cnt), 1);
    check("w1_addr", 32'(hs_addr), 32'h03);
    check("w1_data", 32'(hs_data), 32'hA);
    check("w1_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 0);

    // One-cycle low glitch in IDLE.
    rx = 1'b0; tick(1); rx = 1'b1; tick(3);
    check("glitch_busy", 32'(busy), 1);
    tick(10);
    check("glitch_idle", 32'(busy), 0);
    check("glitch_vld", 32'(vld_cyc), 1);
    check("glitch_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 0);

    // Framing error, then a good frame.
    send(8'h3A, 1'b0, 1'b0, 1'b0);
    check("fe_cnt", 32'(fe_cnt), 1);
    check("fe_no_vld", 32'(vld_cyc), 1);
    send(8'h27, 1'b1, 1'b0, 1'b0);
    check("fe_next_hs", 32'(hs_cnt), 2);
    check("fe_next_addr", 32'(hs_addr), 32'h02);
    check("fe_next_data", 32'(hs_data), 32'h7);
    check("fe_cnt_hold", 32'(fe_cnt), 1);

    // Overrun while the consumer stalls.
    out_ready = 1'b0;
    send(8'h3A, 1'b1, 1'b0, 1'b0);
    send(8'h27, 1'b1, 1'b0, 1'b0);
    check("ov_valid", 32'(out_valid), 1);
    check("ov_addr", 32'(out_addr), 32'h03);
    check("ov_data", 32'(out_data), 32'hA);
    check("ov_cnt", 32'(ov_cnt), 1);
    check("ov_no_hs", 32'(hs_cnt), 2);
    out_ready = 1'b1;
    tick(1);
    check("ov_hs", 32'(hs_cnt), 3);
    check("ov_hs_addr", 32'(hs_addr), 32'h03);
    check("ov_cleared", 32'(out_valid), 0);
    tick(5);
    check("ov_single_hs", 32'(hs_cnt), 3);

    // Bank select then banked write.
    send(8'h82, 1'b1, 1'b0, 1'b0);
    check("bank_sel", 32'(bank_sel), 32'h2);
    check("bank_no_hs", 32'(hs_cnt), 3);
    send(8'h51, 1'b1, 1'b0, 1'b0);
    check("bank_hs", 32'(hs_cnt), 4);
    check("bank_addr", 32'(hs_addr), 32'h15);
    check("bank_data", 32'(hs_data), 32'h1);

    // Even parity: bad bit dropped, good bit accepted.
    send(8'h3A, 1'b1, 1'b1, 1'b1);
    check("par_err", 32'(pe_p), 1);
    check("par_no_wr", 32'(hs_p), 0);
    send(8'h3A, 1'b1, 1'b1, 1'b0);
    check("par_wr", 32'(hs_p), 1);
    check("par_addr", 32'(hs_addr_p), 32'h03);
    check("par_data", 32'(hs_data_p), 32'hA);
    check("par_err_hold", 32'(pe_p + fe_p), 1);

    // Reset in the middle of the payload.
    rx = 1'b0; tick(OS);
    rx = 1'b1; tick(OS);
    rx = 1'b0; tick(OS);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick(2);
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_bank", 32'(bank_sel), 0);
    check("mrst_addr", 32'(out_addr), 0);
    check("mrst_data", 32'(out_data), 0);
    rx = 1'b1;
    rst = 1'b0;
    tick(8 * OS);
    check("mrst_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 2);
    check("mrst_no_hs", 32'(hs_cnt), 4);
    send(8'h3A, 1'b1, 1'b0, 1'b0);
    check("post_hs", 32'(hs_cnt), 5);
    check("post_addr", 32'(hs_addr), 32'h03);
    check("post_data", 32'(hs_data), 32'hA);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
